// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Each bit is the majority of three mid-bit samples; good bytes are strobed out on Data_Valid.
module uart_rx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       Data_Valid,
  output logic       Parity_Error,
  output logic       Stop_Error
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;
  localparam int unsigned TW = 5;
  localparam int unsigned BW = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          sync1, rx_s;
  logic [TW-1:0] tick, tick_nxt;
  logic [TW-1:0] p_last, p_last_nxt, p_last_in;
  logic [TW-1:0] half;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]    smp, smp_nxt;
  logic [DW-1:0] shift_reg, shift_nxt, p_data_nxt;
  logic          par_en_q, par_en_nxt, par_typ_q, par_typ_nxt;
  logic          par_err, par_err_nxt;
  logic          dv_nxt, pe_nxt, se_nxt;
  logic          maj, smp_tick, eval_tick, last_tick;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      rx_s  <= sync1;
    end
  end

  // Anything other than 16 or 32 falls back to x8 oversampling
  always_comb begin
    p_last_in = TW'(7);
    if (Prescale == PW'(16))      p_last_in = TW'(15);
    else if (Prescale == PW'(32)) p_last_in = TW'(31);
  end

  assign half      = (p_last >> 1) + TW'(1);
  assign smp_tick  = (tick == half - TW'(1)) || (tick == half) || (tick == half + TW'(1));
  assign eval_tick = (tick == half + TW'(2));
  assign last_tick = (tick == p_last);
  assign maj       = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= IDLE;
      tick         <= '0;
      p_last       <= TW'(7);
      bit_cnt      <= '0;
      smp          <= '0;
      shift_reg    <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_err      <= 1'b0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick         <= tick_nxt;
      p_last       <= p_last_nxt;
      bit_cnt      <= bit_cnt_nxt;
      smp          <= smp_nxt;
      shift_reg    <= shift_nxt;
      par_en_q     <= par_en_nxt;
      par_typ_q    <= par_typ_nxt;
      par_err      <= par_err_nxt;
      P_DATA       <= p_data_nxt;
      Data_Valid   <= dv_nxt;
      Parity_Error <= pe_nxt;
      Stop_Error   <= se_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_nxt    = last_tick ? '0 : tick + TW'(1);
    p_last_nxt  = p_last;
    bit_cnt_nxt = bit_cnt;
    smp_nxt     = smp_tick ? {smp[1:0], rx_s} : smp;
    shift_nxt   = shift_reg;
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
    par_err_nxt = par_err;
    p_data_nxt  = P_DATA;
    dv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    se_nxt      = 1'b0;

    case (state)
      IDLE: begin
        tick_nxt    = '0;
        bit_cnt_nxt = '0;
        // The cycle that sees the low line is tick 0 of the start bit
        if (!rx_s) begin
          state_nxt   = START;
          tick_nxt    = TW'(1);
          p_last_nxt  = p_last_in;
          par_en_nxt  = PAR_EN;
          par_typ_nxt = PAR_TYP;
          par_err_nxt = 1'b0;
        end
      end
      START: begin
        if (eval_tick && maj) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
        end else if (last_tick) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (eval_tick) shift_nxt[bit_cnt] = maj;
        if (last_tick) begin
          bit_cnt_nxt = bit_cnt + BW'(1);
          if (bit_cnt == BW'(DW - 1)) state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (eval_tick) par_err_nxt = ((^shift_reg) ^ maj) != par_typ_q;
        if (last_tick) state_nxt = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so the next start edge has half a bit of margin
        if (eval_tick) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          if (!maj) begin
            se_nxt = 1'b1;
          end else if (par_err) begin
            pe_nxt = 1'b1;
          end else begin
            dv_nxt     = 1'b1;
            p_data_nxt = shift_reg;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random traffic, checked every cycle against a
// model that decodes frames from the recorded synchronized line using bit-position arithmetic.
module tb_uart_rx;

  localparam int MAXC = 65536;

  logic       clk = 1'b0;
  logic       rst, rx_in, par_en, par_typ;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid, parity_error, stop_error;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  uart_rx dut (
    .CLK(clk), .RST(rst), .RX_IN(rx_in), .Prescale(prescale),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .P_DATA(p_data),
    .Data_Valid(data_valid), .Parity_Error(parity_error), .Stop_Error(stop_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: rxs[c] is the synchronized line value during the cycle opened by edge c
  bit       rxs [MAXC];
  bit       rxin_prev = 1'b1;
  bit       rst_prev  = 1'b0;
  bit       rx_s_m, busy;
  int       t0, mp, mn, c;
  bit       men, mtyp;
  bit       sched_dv, sched_pe, sched_se;
  logic [7:0] sched_pd;
  bit       exp_dv, exp_pe, exp_se;
  logic [7:0] exp_pd;
  logic [7:0] md;
  bit       mpb, msb, mperr;

  int n_dv = 0, n_pe = 0, n_se = 0;
  int last_dv_cyc = -1, last_pe_cyc = -1, last_se_cyc = -1;
  int last_pd = 0;

  function automatic int p_of(input logic [5:0] v);
    if (v == 6'd16) return 16;
    if (v == 6'd32) return 32;
    return 8;
  endfunction

  // Majority of the three mid-bit samples of the bit that starts at cycle base
  function automatic bit maj_at(input int base, input int p);
    int m;
    m = base + p / 2;
    return (int'(rxs[m-1]) + int'(rxs[m]) + int'(rxs[m+1])) >= 2;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Model + per-cycle compare, one step per cycle, 1 time unit after the edge
  initial begin
    busy = 1'b0; sched_dv = 0; sched_pe = 0; sched_se = 0; sched_pd = '0;
    exp_dv = 0; exp_pe = 0; exp_se = 0; exp_pd = '0;
    t0 = 0; mp = 8; mn = 10; men = 0; mtyp = 0;
    forever begin
      @(posedge clk);
      #1;
      c = cyc;
      rx_s_m = (rst && rst_prev) ? rxin_prev : 1'b1;
      if (c < MAXC) rxs[c] = rx_s_m;
      if (!rst) begin
        busy = 1'b0;
        sched_dv = 0; sched_pe = 0; sched_se = 0;
        exp_dv = 0; exp_pe = 0; exp_se = 0; exp_pd = 8'h00;
      end else begin
        exp_dv = sched_dv; exp_pe = sched_pe; exp_se = sched_se;
        if (sched_dv) exp_pd = sched_pd;
        sched_dv = 0; sched_pe = 0; sched_se = 0;
        if (busy) begin
          if (c == t0 + 1) begin
            mp = p_of(prescale); men = par_en; mtyp = par_typ;
            mn = men ? 11 : 10;
          end else if (c == t0 + mp / 2 + 2 && maj_at(t0, mp)) begin
            busy = 1'b0;
          end else if (c == t0 + (mn - 1) * mp + mp / 2 + 2) begin
            for (int b = 1; b <= 8; b++) md[b-1] = maj_at(t0 + b * mp, mp);
            mpb   = men ? maj_at(t0 + 9 * mp, mp) : 1'b0;
            msb   = maj_at(t0 + (mn - 1) * mp, mp);
            mperr = men && (((^md) ^ mpb) != mtyp);
            sched_se = !msb;
            sched_pe = msb && mperr;
            sched_dv = msb && !mperr;
            sched_pd = md;
            busy = 1'b0;
          end
        end else if (!rx_s_m) begin
          busy = 1'b1;
          t0 = c;
        end
      end
      rxin_prev = rx_in;
      rst_prev  = rst;

      checks++;
      if (data_valid !== exp_dv || parity_error !== exp_pe ||
          stop_error !== exp_se || p_data !== exp_pd) begin
        errors++;
        $display("FAIL cycle %0d outputs dv/pe/se/pdata: got %b/%b/%b/%02h want %b/%b/%b/%02h",
                 c, data_valid, parity_error, stop_error, p_data, exp_dv, exp_pe, exp_se, exp_pd);
      end
      if (data_valid === 1'b1) begin n_dv++; last_dv_cyc = c; last_pd = int'(p_data); end
      if (parity_error === 1'b1) begin n_pe++; last_pe_cyc = c; end
      if (stop_error === 1'b1) begin n_se++; last_se_cyc = c; end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
      rst   = 1'b1;
    end
  endtask

  // Drive one frame at p cycles per bit; optional one-cycle inversion and reset pulse
  task automatic send(input logic [7:0] d, input int p, input bit pen, input bit pbit,
                      input bit sbit, input int glitch, input int rst_at, output int k);
    logic [10:0] bits;
    int nb;
    bits = pen ? {sbit, pbit, d, 1'b0} : {1'b1, sbit, d, 1'b0};
    nb = pen ? 11 : 10;
    k = 0;
    for (int i = 0; i < nb * p; i++) begin
      @(negedge clk);
      if (i == 0) k = cyc;
      rx_in = bits[i / p] ^ (i == glitch);
      rst   = (i == rst_at) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    int k, pv, p, nb, g, r, gap;
    logic [7:0] d;
    bit pen, ptyp, pb, sb;

    rst = 1'b0; rx_in = 1'b1; prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(5);
    check("reset_pdata", int'(p_data), 0);
    check("reset_strobes", int'({data_valid, parity_error, stop_error}), 0);

    // Good frame, x16, no parity: strobe 155 cycles after the first low rx_s cycle (k+2)
    send(8'hA5, 16, 0, 0, 1, -1, -1, k);
    idle(10);
    check("a5_dv_count", n_dv, 1);
    check("a5_latency", last_dv_cyc, k + 2 + 155);
    check("a5_data", last_pd, 8'hA5);
    check("a5_no_err", n_pe + n_se, 0);

    // Even parity, x8: good then bad parity
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    send(8'h3C, 8, 1, 0, 1, -1, -1, k);
    idle(10);
    check("3c_latency", last_dv_cyc, k + 2 + 87);
    check("3c_data", last_pd, 8'h3C);
    send(8'h3D, 8, 1, 0, 1, -1, -1, k);
    idle(10);
    check("3d_pe_count", n_pe, 1);
    check("3d_pe_latency", last_pe_cyc, k + 2 + 87);
    check("3d_no_dv", n_dv, 2);
    check("3d_pdata_held", int'(p_data), 8'h3C);

    // Stop-bit error, then recovery
    prescale = 6'd16; par_en = 1'b0;
    send(8'h55, 16, 0, 0, 0, -1, -1, k);
    idle(60);
    check("55_se_count", n_se, 1);
    check("55_se_latency", last_se_cyc, k + 2 + 155);
    check("55_no_dv", n_dv, 2);
    send(8'h12, 16, 0, 0, 1, -1, -1, k);
    idle(10);
    check("12_data", last_pd, 8'h12);
    check("12_dv_count", n_dv, 3);

    // Short start glitch, then a frame with one noisy sample in data bit 0
    repeat (3) begin @(negedge clk); rx_in = 1'b0; end
    idle(40);
    check("glitch_no_strobe", n_dv + n_pe + n_se, 5);
    send(8'h81, 16, 0, 0, 1, 16 + 8, -1, k);
    idle(10);
    check("81_data", last_pd, 8'h81);
    check("81_dv_count", n_dv, 4);

    // Back-to-back, x32, odd parity
    prescale = 6'd32; par_en = 1'b1; par_typ = 1'b1;
    send(8'h00, 32, 1, 1, 1, -1, -1, k);
    check("b2b_first_data", last_pd, 8'h00);
    check("b2b_first_latency", last_dv_cyc, k + 2 + 339);
    send(8'hFF, 32, 1, 1, 1, -1, -1, k);
    idle(30);
    check("b2b_second_data", last_pd, 8'hFF);
    check("b2b_dv_count", n_dv, 6);
    check("b2b_no_err", n_pe + n_se, 2);

    // Reset during data bit 4 abandons the frame
    prescale = 6'd16; par_en = 1'b0;
    send(8'hF7, 16, 0, 0, 1, -1, 4 * 16 + 16 + 5, k);
    idle(10);
    check("rst_pdata_cleared", int'(p_data), 0);
    check("rst_no_dv", n_dv, 6);
    send(8'hC3, 16, 0, 0, 1, -1, -1, k);
    idle(10);
    check("c3_data", last_pd, 8'hC3);
    check("c3_dv_count", n_dv, 7);

    // Random traffic checked by the per-cycle model
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 6))
        0: pv = 8;
        1: pv = 16;
        2: pv = 32;
        3: pv = 0;
        4: pv = 12;
        5: pv = 63;
        default: pv = int'($urandom_range(0, 63));
      endcase
      p    = p_of(6'(pv));
      d    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      pb   = (^d) ^ ptyp ^ ($urandom_range(0, 4) == 0);
      sb   = ($urandom_range(0, 6) != 0);
      nb   = pen ? 11 : 10;
      g    = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, nb * p - 1)) : -1;
      r    = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, nb * p - 1)) : -1;
      gap  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
      prescale = 6'(pv); par_en = pen; par_typ = ptyp;
      send(d, p, pen, pb, sb, g, r, k);
      idle(gap);
    end
    idle(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
